jt12_cen_div: RTL
=================

# jt12_cen_div

Parametrised clock-enable generator for the JT12 core. It replaces fixed derived clocks with single-cycle enable pulses on the master clock. The division ratio is programmable at run time and changes only at period boundaries, so no enable pulse is ever shortened or duplicated. It also generates the internal synchronous reset that the operator and envelope pipelines consume.

## Interface
Parameters:
- `W`, 4: width of the divider ratio and the period counter; must be ≥3.
- `DIV_RST`, 6: ratio loaded on reset; must be in 1..2^W−1.
- `RSTLEN`, 2: number of `cen` pulses for which `rst_int` stays high after reset release; must be ≥1.

Ports:
- `clk` in 1: master clock; every flop in the block is clocked on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `div` in W: requested ratio; values 0 and 1 both mean divide-by-1.
- `cen` out 1: one-`clk` enable pulse, once per period.
- `cen_half` out 1: enable pulse on every second `cen`.
- `rst_int` out 1: internal synchronous reset, aligned to `cen`.
- `div_ack` out 1: one-cycle pulse when a new ratio takes effect.

## Operation
- State:
  - `cnt` (W bits): period counter.
  - `cur` (W bits): active ratio.
  - `h`: half-rate phase bit.
  - `rcnt`: reset-stretch counter, sized for `RSTLEN`.
- `eff(div)` = 1 if `div` ≤ 1, otherwise `div`.
- `wrap` = (`cnt` == `cur`−1).
- Each edge when `rst` is low:
  - `cnt` ← `wrap` ? 0 : `cnt`+1.
  - `cen` ← `wrap`.
  - `cen_half` ← `wrap` & `h`.
  - If `wrap`: `h` ← ~`h`.
  - If `wrap`: `cur` ← `eff(div)`, and `div_ack` ← (`eff(div)` ≠ `cur`). Otherwise `div_ack` ← 0.
  - `rst_int`: while it is 1, each `wrap` increments `rcnt`. The `wrap` taken when `rcnt` == `RSTLEN`−1 clears `rst_int` to 0. It then stays 0 until the next `rst`.
- `div` is sampled only on a `wrap` edge. Changes between wraps are ignored; only the value present at the wrap applies.
- When `cur` = 1, `wrap` is true every cycle: `cen` is held high continuously and `cen_half` toggles every cycle.

## Timing
- Reset values, all applied on the first edge with `rst` high:
  - `cnt`=0, `cur`=`DIV_RST`, `h`=0, `rcnt`=0.
  - `cen`=0, `cen_half`=0, `div_ack`=0, `rst_int`=1.
- First `cen` goes high after the `DIV_RST`-th rising edge following `rst` release. After that, `cen` repeats every `cur` cycles.
- The new ratio takes effect from the period that begins on the wrap edge. The `div_ack` pulse coincides with the `cen` of that same wrap.
- `cen_half` is first high on the 2nd `cen`, then on every 2nd `cen` after that. It is never high without `cen`.
- `rst_int` falls on the same edge on which the `RSTLEN`-th `cen` rises.
- `rst` asserted mid-period aborts the period with no `cen` pulse. All state returns to reset values on that edge, and `rst_int` reasserts.
- No combinational path from any input to any output: all outputs are registered.

## Configuration
- `JT12_CEN_LEGACY_EN` defined:
  - Adds inputs `set_n6`, `set_n3`, `set_n2` (1 bit each).
  - `div` is ignored.
  - `eff` is decoded from {`set_n3`,`set_n2`}: 2'b10 → 3, 2'b01 → 2, any other value → 6. `set_n6` has no effect.
  - The decode is sampled at wrap exactly as `div` would be.
- `JT12_CEN_LEGACY_EN` undefined: the `set_*` ports are absent, and the ratio comes from `div`.

## Test plan
- Reset release with `div`=6 (`DIV_RST`=6):
  - `cen` on cycles 6, 12, 18.
  - `cen_half` on cycles 12 and 24.
  - `rst_int` falls on cycle 12.
  - `div_ack` stays 0.
- Ratio change mid-period: `div` goes 6→3 at cycle 8.
  - Next `cen` at 12 with `div_ack`=1.
  - Following `cen` pulses at 15 and 18.
- `div`=0 and `div`=1: after the first wrap, `cen` is held high continuously and `cen_half` alternates every cycle.
- `rst` pulsed at cycle 4 of a 6-cycle period:
  - No `cen` in that period.
  - Next `cen` 6 cycles after release.
  - `rst_int`=1 again until the 2nd `cen`.
- Glitch on `div`: 6→2→6 between wraps. No `div_ack` and no change in period.
- With `JT12_CEN_LEGACY_EN`:
  - {`set_n3`,`set_n2`}=10 gives a period of 3.
  - 01 gives a period of 2.
  - 11 gives a period of 6.
  - Each change applies at the next wrap with `div_ack`.

Source files
------------

// File: rtl/jt12_cen_div.sv
// jt12_cen_div: programmable clock-enable divider with half-rate enable, ratio-change ack and stretched internal reset; define JT12_CEN_LEGACY_EN to take the ratio from set_n3/set_n2 instead of div
module jt12_cen_div #(
  parameter int W = 4,
  parameter int DIV_RST = 6,
  parameter int RSTLEN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] div,
`ifdef JT12_CEN_LEGACY_EN
  input  logic         set_n6,
  input  logic         set_n3,
  input  logic         set_n2,
`endif
  output logic         cen,
  output logic         cen_half,
  output logic         rst_int,
  output logic         div_ack
);
  localparam int RW = RSTLEN > 1 ? $clog2(RSTLEN) : 1;
  logic [W-1:0]  cnt, cur, eff;
  logic          h, wrap;
  logic [RW-1:0] rcnt;
`ifdef JT12_CEN_LEGACY_EN
  logic unused_in;
  assign unused_in = ^{div, set_n6};
  // legacy prescaler decode: n3 selects /3, n2 selects /2, anything else /6
  always_comb
    eff = {set_n3, set_n2} == 2'b10 ? W'(3) : {set_n3, set_n2} == 2'b01 ? W'(2) : W'(6);
`else
  // ratios 0 and 1 both collapse to divide-by-1
  always_comb
    eff = div > W'(1) ? div : W'(1);
`endif
  assign wrap = cnt == cur - W'(1);
  // period counter, enables, ratio reload at wrap and reset stretching
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cur      <= W'(DIV_RST);
      h        <= 1'b0;
      rcnt     <= '0;
      cen      <= 1'b0;
      cen_half <= 1'b0;
      div_ack  <= 1'b0;
      rst_int  <= 1'b1;
    end else begin
      cnt      <= wrap ? '0 : cnt + W'(1);
      cen      <= wrap;
      cen_half <= wrap & h;
      div_ack  <= wrap && eff != cur;
      if (wrap) begin
        h   <= ~h;
        cur <= eff;
      end
      if (wrap && rst_int) begin
        rcnt <= rcnt + RW'(1);
        if (rcnt == RW'(RSTLEN - 1)) rst_int <= 1'b0;
      end
    end
  end
endmodule
